// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared definitions for the UART command controller and its helpers.
package uart_cmd_ctrl_pkg;

   // State encodings for the frame FSM.
   typedef enum logic [2:0] {
      S_SYNC   = 3'd0,
      S_ADDR   = 3'd1,
      S_DATA   = 3'd2,
      S_CSUM   = 3'd3,
      S_COMMIT = 3'd4
   } state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
   localparam int         FRAME_BYTES       = 4;

   // Frame checksum: modulo-256 sum of address and data bytes.
   function automatic logic [7:0] frame_csum(input logic [7:0] addr, input logic [7:0] data);
      return addr + data;
   endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte idle timer. Counts while run is high and pulses expired on the
// terminal count; cleared by clear, by run dropping, or by its own expiry.
module uart_frame_timer #(
   parameter int CYCLES = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int TW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [TW-1:0] LAST = TW'(CYCLES - 1);

   logic [TW-1:0] count_q;
   logic [TW-1:0] count_d;

   assign expired = run && (count_q == LAST);

   // Next count: hold at zero when idle, cleared or just expired.
   always_comb begin
      count_d = count_q + TW'(1);
      if (clear || !run || expired) begin
         count_d = '0;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame-level controller behind uart_rx: SYNC, ADDR, DATA, CSUM frames become
// register writes; malformed, errored or stalled frames bump a saturating count.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_SYNC   | hunting for the sync byte, other bytes silently dropped
// S_ADDR   | waiting for the address byte
// S_DATA   | waiting for the data byte
// S_CSUM   | waiting for the checksum byte, then validate
// S_COMMIT | one cycle where the write is visible on the outputs
module uart_cmd_ctrl
   import uart_cmd_ctrl_pkg::*;
#(
   parameter int         CLOCK_RATE     = 100000000,
   parameter int         TIMEOUT_CYCLES = CLOCK_RATE / 1000,
   parameter int         NUM_REGS       = 4,
   parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_ready,
   input  logic [7:0]            rx_val,
   input  logic                  rx_error,
   output logic [7:0]            led,
   output logic [8*NUM_REGS-1:0] regs,
   output logic                  wr_strobe,
   output logic [7:0]            wr_addr,
   output logic                  frame_ok,
   output logic [7:0]            err_cnt
);

   state_t     state_q, state_d;
   logic       rx_ready_q;
   logic       arm_q;
   logic [7:0] addr_q, addr_d;
   logic [7:0] data_q, data_d;
   logic [7:0] regs_q [NUM_REGS];
   logic [7:0] regs_d [NUM_REGS];
   logic       wr_strobe_q, wr_strobe_d;
   logic       frame_ok_q, frame_ok_d;
   logic [7:0] wr_addr_q, wr_addr_d;
   logic [7:0] err_cnt_q, err_cnt_d;
   logic       err_inc;
   logic       byte_event;
   logic       timer_run;
   logic       timer_expired;
   logic       csum_ok;
   logic       addr_ok;

   // arm_q masks the first cycle after reset: rx_ready_q resets low, so a level
   // already high at release would otherwise look like a fresh rising edge.
   assign byte_event = rx_ready && !rx_ready_q && arm_q;
   assign timer_run  = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_CSUM);
   assign csum_ok    = (rx_val == frame_csum(addr_q, data_q));
   // 9-bit compare so NUM_REGS = 256 accepts every address.
   assign addr_ok    = ({1'b0, addr_q} < 9'(NUM_REGS));

   uart_frame_timer #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (byte_event),
      .run     (timer_run),
      .expired (timer_expired)
   );

   // Next-state, register-file and error-count logic; a byte beats a timeout.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      data_d      = data_q;
      regs_d      = regs_q;
      wr_strobe_d = 1'b0;
      frame_ok_d  = 1'b0;
      wr_addr_d   = wr_addr_q;
      err_inc     = 1'b0;
      unique case (state_q)
         S_SYNC: begin
            if (byte_event) begin
               if (rx_error) begin
                  err_inc = 1'b1;
               end else if (rx_val == SYNC_BYTE) begin
                  state_d = S_ADDR;
               end
            end
         end
         S_ADDR, S_DATA, S_CSUM: begin
            if (byte_event) begin
               if (rx_error) begin
                  err_inc = 1'b1;
                  state_d = S_SYNC;
               end else if (state_q == S_ADDR) begin
                  addr_d  = rx_val;
                  state_d = S_DATA;
               end else if (state_q == S_DATA) begin
                  data_d  = rx_val;
                  state_d = S_CSUM;
               end else if (csum_ok && addr_ok) begin
                  state_d     = S_COMMIT;
                  wr_strobe_d = 1'b1;
                  frame_ok_d  = 1'b1;
                  wr_addr_d   = addr_q;
                  for (int i = 0; i < NUM_REGS; i++) begin
                     if (9'(i) == {1'b0, addr_q}) begin
                        regs_d[i] = data_q;
                     end
                  end
               end else begin
                  err_inc = 1'b1;
                  state_d = S_SYNC;
               end
            end else if (timer_expired) begin
               err_inc = 1'b1;
               state_d = S_SYNC;
            end
         end
         S_COMMIT: begin
            state_d = S_SYNC;
         end
         default: begin
            state_d = S_SYNC;
         end
      endcase
      err_cnt_d = (err_inc && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
   end

   // State, register file and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_SYNC;
         rx_ready_q  <= 1'b0;
         arm_q       <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         wr_strobe_q <= 1'b0;
         frame_ok_q  <= 1'b0;
         wr_addr_q   <= '0;
         err_cnt_q   <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         rx_ready_q  <= rx_ready;
         arm_q       <= 1'b1;
         addr_q      <= addr_d;
         data_q      <= data_d;
         wr_strobe_q <= wr_strobe_d;
         frame_ok_q  <= frame_ok_d;
         wr_addr_q   <= wr_addr_d;
         err_cnt_q   <= err_cnt_d;
         regs_q      <= regs_d;
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
      assign regs[8*g +: 8] = regs_q[g];
   end

   assign led       = regs_q[0];
   assign wr_strobe = wr_strobe_q;
   assign frame_ok  = frame_ok_q;
   assign wr_addr   = wr_addr_q;
   assign err_cnt   = err_cnt_q;

endmodule
